// File: rtl/apb2axi_pkg.sv
// Shared widths and FIFO entry layouts for the APB-to-AXI bridge.
package apb2axi_pkg;

   localparam int TAG_W       = 4;
   localparam int AXI_ID_W    = 4;
   localparam int AXI_DATA_W  = 64;
   localparam int DIR_ENTRIES = 1 << TAG_W;

   typedef struct packed {
      logic [TAG_W-1:0]      tag;
      logic [AXI_DATA_W-1:0] data;
      logic                  last;
      logic [1:0]            resp;
   } rdf_entry_t;

   typedef struct packed {
      logic             is_write;
      logic [TAG_W-1:0] tag;
      logic [1:0]       resp;
      logic             error;
      logic [7:0]       num_beats;
   } completion_entry_t;

   localparam int RDF_W        = $bits(rdf_entry_t);
   localparam int COMPLETION_W = $bits(completion_entry_t);

endpackage

// File: rtl/apb2axi_rd_collector_if.sv
// AR-issue notification, AXI R channel and the two FIFO push ports of the read collector.
interface apb2axi_rd_collector_if;
   import apb2axi_pkg::*;

   logic                  ar_issue_valid;
   logic [TAG_W-1:0]      ar_issue_tag;
   logic [7:0]            ar_issue_len;

   logic                  rvalid;
   logic                  rready;
   logic [AXI_ID_W-1:0]   rid;
   logic [AXI_DATA_W-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;

   logic                  rdf_push;
   rdf_entry_t            rdf_entry;
   logic                  rdf_full;

   logic                  cpl_push;
   completion_entry_t     cpl_entry;
   logic                  cpl_full;

   logic                  err_unexpected;

   modport slave (
      input  ar_issue_valid, ar_issue_tag, ar_issue_len,
      input  rvalid, rid, rdata, rresp, rlast,
      output rready,
      output rdf_push, rdf_entry,
      input  rdf_full,
      output cpl_push, cpl_entry,
      input  cpl_full,
      output err_unexpected
   );

   modport master (
      output ar_issue_valid, ar_issue_tag, ar_issue_len,
      output rvalid, rid, rdata, rresp, rlast,
      input  rready,
      input  rdf_push, rdf_entry,
      output rdf_full,
      input  cpl_push, cpl_entry,
      output cpl_full,
      input  err_unexpected
   );

endinterface

// File: rtl/apb2axi_rd_collector.sv
// Per-tag AXI read-burst collector: beats pass straight to the read-data FIFO, burst end pushes a completion.
// Zero-latency push path; rready drops whenever either FIFO is full. APB2AXI_RLEN_CHECK_EN adds ARLEN checking.
module apb2axi_rd_collector
   import apb2axi_pkg::*;
(
   input  logic                   aclk,
   input  logic                   aresetn,
   apb2axi_rd_collector_if.slave  bus
);

   logic [DIR_ENTRIES-1:0] active_q, active_d;
   logic [7:0]             beat_cnt_q [DIR_ENTRIES];
   logic [7:0]             beat_cnt_d [DIR_ENTRIES];
   logic [1:0]             resp_acc_q [DIR_ENTRIES];
   logic [1:0]             resp_acc_d [DIR_ENTRIES];
`ifdef APB2AXI_RLEN_CHECK_EN
   logic [7:0]             exp_len_q  [DIR_ENTRIES];
   logic [7:0]             exp_len_d  [DIR_ENTRIES];
`endif
   logic                   err_q, err_d;

   logic [TAG_W-1:0] r_tag;
   logic [TAG_W-1:0] a_tag;
   logic             rready_w;
   logic             beat_acc;
   logic             r_active;
   logic             hit;
   logic [7:0]       cur_cnt;
   logic [7:0]       cnt_inc;
   logic [1:0]       cur_acc;
   logic [1:0]       resp_max;
   logic             last_eff;
   logic             len_err;
   logic             early_end;
   logic             cpl_fire;
   logic             issue_ok;
   logic             issue_err;
   logic             cpl_error;

   assign r_tag    = bus.rid[TAG_W-1:0];
   assign a_tag    = bus.ar_issue_tag;
   assign rready_w = aresetn && !bus.rdf_full && !bus.cpl_full;
   assign beat_acc = bus.rvalid && rready_w;
   assign r_active = active_q[r_tag];
   assign hit      = beat_acc && r_active;
   assign cur_cnt  = beat_cnt_q[r_tag];
   assign cur_acc  = resp_acc_q[r_tag];
   assign cnt_inc  = (cur_cnt == 8'hFF) ? 8'hFF : cur_cnt + 8'd1;
   assign resp_max = (bus.rresp > cur_acc) ? bus.rresp : cur_acc;

`ifdef APB2AXI_RLEN_CHECK_EN
   logic len_hit;
   assign len_hit   = (cur_cnt == exp_len_q[r_tag]);
   // Reaching the expected count without rlast ends the burst early, flagged as an error.
   assign last_eff  = bus.rlast || len_hit;
   assign early_end = !bus.rlast && len_hit;
   assign len_err   = bus.rlast ^ len_hit;
`else
   logic unused_len;
   assign unused_len = ^bus.ar_issue_len;
   assign last_eff   = bus.rlast;
   assign early_end  = 1'b0;
   assign len_err    = 1'b0;
`endif

   assign cpl_fire  = hit && last_eff;
   assign cpl_error = (resp_max >= 2'd2) || len_err;

   // A tag finishing this cycle may be re-issued in the same cycle without error.
   assign issue_ok  = bus.ar_issue_valid &&
                      (!active_q[a_tag] || (cpl_fire && (r_tag == a_tag)));
   assign issue_err = bus.ar_issue_valid && !issue_ok;

   assign err_d = issue_err || (beat_acc && !r_active) || (hit && early_end);

   always_comb begin
      active_d   = active_q;
      beat_cnt_d = beat_cnt_q;
      resp_acc_d = resp_acc_q;
`ifdef APB2AXI_RLEN_CHECK_EN
      exp_len_d  = exp_len_q;
`endif
      if (hit) begin
         if (last_eff) begin
            active_d[r_tag] = 1'b0;
         end else begin
            beat_cnt_d[r_tag] = cnt_inc;
            resp_acc_d[r_tag] = resp_max;
         end
      end
      if (issue_ok) begin
         active_d[a_tag]   = 1'b1;
         beat_cnt_d[a_tag] = 8'd0;
         resp_acc_d[a_tag] = 2'd0;
`ifdef APB2AXI_RLEN_CHECK_EN
         exp_len_d[a_tag]  = bus.ar_issue_len;
`endif
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         active_q <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < DIR_ENTRIES; i++) begin
            beat_cnt_q[i] <= 8'd0;
            resp_acc_q[i] <= 2'd0;
`ifdef APB2AXI_RLEN_CHECK_EN
            exp_len_q[i]  <= 8'd0;
`endif
         end
      end else begin
         active_q   <= active_d;
         err_q      <= err_d;
         beat_cnt_q <= beat_cnt_d;
         resp_acc_q <= resp_acc_d;
`ifdef APB2AXI_RLEN_CHECK_EN
         exp_len_q  <= exp_len_d;
`endif
      end
   end

   always_comb begin
      bus.rdf_entry = '0;
      bus.cpl_entry = '0;
      if (aresetn) begin
         bus.rdf_entry.tag       = r_tag;
         bus.rdf_entry.data      = bus.rdata;
         bus.rdf_entry.last      = bus.rlast;
         bus.rdf_entry.resp      = bus.rresp;
         bus.cpl_entry.is_write  = 1'b0;
         bus.cpl_entry.tag       = r_tag;
         bus.cpl_entry.resp      = resp_max;
         bus.cpl_entry.error     = cpl_error;
         bus.cpl_entry.num_beats = cnt_inc;
      end
   end

   assign bus.rready         = rready_w;
   assign bus.rdf_push       = hit;
   assign bus.cpl_push       = cpl_fire;
   assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_apb2axi_rd_collector.sv
// Scoreboard bench for the read collector: directed bursts push expected FIFO entries, a negedge monitor pops and compares.
module tb_apb2axi_rd_collector;
   import apb2axi_pkg::*;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;

   apb2axi_rd_collector_if bif ();

   apb2axi_rd_collector dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bif)
   );

   always #5 aclk = ~aclk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int err_cnt   = 0;

   rdf_entry_t        rdf_q [$];
   completion_entry_t cpl_q [$];

   typedef struct {
      logic rdf_full;
      logic cpl_full;
      logic exp_rready;
   } vec_t;
   vec_t vt [4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge aclk) begin : mon
      rdf_entry_t        er;
      completion_entry_t ec;
      if (aresetn) begin
         if (bif.err_unexpected) err_cnt++;
         if (bif.rdf_push) begin
            chk("rdf_push_while_full", bif.rdf_full, 1'b0);
            if (rdf_q.size() == 0) chk("rdf_unexpected_push", 1'b1, 1'b0);
            else begin
               er = rdf_q.pop_front();
               chk("rdf_entry", bif.rdf_entry, er);
            end
         end
         if (bif.cpl_push) begin
            chk("cpl_push_while_full", bif.cpl_full, 1'b0);
            if (cpl_q.size() == 0) chk("cpl_unexpected_push", 1'b1, 1'b0);
            else begin
               ec = cpl_q.pop_front();
               chk("cpl_entry", bif.cpl_entry, ec);
            end
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic issue(input logic [3:0] tag, input logic [7:0] len);
      bif.ar_issue_valid = 1'b1;
      bif.ar_issue_tag   = tag;
      bif.ar_issue_len   = len;
      tick();
      bif.ar_issue_valid = 1'b0;
   endtask

   task automatic beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] rs,
                       input logic lst, input bit exp_rdf, input bit exp_cpl,
                       input logic [1:0] c_resp, input logic c_err, input logic [7:0] c_nb,
                       input int stall, input bit stall_cpl);
      rdf_entry_t        er;
      completion_entry_t ec;
      int                n;
      bif.rvalid = 1'b1;
      bif.rid    = id;
      bif.rdata  = d;
      bif.rresp  = rs;
      bif.rlast  = lst;
      if (exp_rdf) begin
         er.tag = id; er.data = d; er.last = lst; er.resp = rs;
         rdf_q.push_back(er);
      end
      if (exp_cpl) begin
         ec.is_write = 1'b0; ec.tag = id; ec.resp = c_resp; ec.error = c_err; ec.num_beats = c_nb;
         cpl_q.push_back(ec);
      end
      if (stall > 0) begin
         if (stall_cpl) bif.cpl_full = 1'b1;
         else           bif.rdf_full = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(negedge aclk);
            chk("stall_rready", bif.rready, 1'b0);
            chk("stall_no_push", {bif.rdf_push, bif.cpl_push}, 2'b00);
         end
         tick();
         bif.rdf_full = 1'b0;
         bif.cpl_full = 1'b0;
      end
      n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (!bif.rready && n < 50);
      chk("beat_rready", bif.rready, 1'b1);
      tick();
      bif.rvalid = 1'b0;
      bif.rlast  = 1'b0;
   endtask

   task automatic err_delta(input string name, input int e0, input int exp);
      tick();
      tick();
      chk(name, err_cnt - e0, exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      vt[0] = '{1'b0, 1'b0, 1'b1};
      vt[1] = '{1'b1, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b1, 1'b0};
      vt[3] = '{1'b1, 1'b1, 1'b0};

      // Reset with stimulus pressing on every input.
      bif.ar_issue_valid = 1'b1; bif.ar_issue_tag = 4'd0; bif.ar_issue_len = 8'd0;
      bif.rvalid = 1'b1; bif.rid = 4'd0; bif.rdata = 64'hDEAD_BEEF_0000_0001;
      bif.rresp = 2'd3; bif.rlast = 1'b1; bif.rdf_full = 1'b0; bif.cpl_full = 1'b0;
      repeat (2) @(negedge aclk);
      chk("rst_rready", bif.rready, 1'b0);
      chk("rst_pushes", {bif.rdf_push, bif.cpl_push}, 2'b00);
      chk("rst_err", bif.err_unexpected, 1'b0);
      chk("rst_rdf_entry", bif.rdf_entry, '0);
      chk("rst_cpl_entry", bif.cpl_entry, '0);
      tick();
      bif.ar_issue_valid = 1'b0; bif.rvalid = 1'b0; bif.rlast = 1'b0; bif.rresp = 2'd0;
      aresetn = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) begin
         bif.rdf_full = vt[i].rdf_full;
         bif.cpl_full = vt[i].cpl_full;
         #1;
         chk("tbl_rready", bif.rready, vt[i].exp_rready);
      end
      bif.rdf_full = 1'b0; bif.cpl_full = 1'b0;
      tick();

      // Tag 3, four OKAY beats.
      e0 = err_cnt;
      issue(4'd3, 8'd3);
      for (int i = 0; i < 4; i++)
         beat(4'd3, 64'h3000 + 64'(i), 2'd0, i == 3, 1, i == 3, 2'd0, 1'b0, 8'd4, 0, 0);
      err_delta("err_tag3", e0, 0);

      // Tag 5, SLVERR then OKAY last.
      issue(4'd5, 8'd1);
      beat(4'd5, 64'h5000, 2'd2, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      beat(4'd5, 64'h5001, 2'd0, 1'b1, 1, 1, 2'd2, 1'b1, 8'd2, 0, 0);

      // Tag 1 with a 3-cycle rdf_full stall and a cpl_full stall on the last beat.
      issue(4'd1, 8'd3);
      beat(4'd1, 64'h1000, 2'd0, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      beat(4'd1, 64'h1001, 2'd1, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 3, 0);
      beat(4'd1, 64'h1002, 2'd0, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      beat(4'd1, 64'h1003, 2'd0, 1'b1, 1, 1, 2'd1, 1'b0, 8'd4, 2, 1);

      // Beat on a tag that was never issued.
      e0 = err_cnt;
      beat(4'd7, 64'h7777, 2'd0, 1'b1, 0, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      err_delta("err_unissued", e0, 1);

      // Tag 2: last beat and re-issue in the same cycle.
      e0 = err_cnt;
      issue(4'd2, 8'd1);
      beat(4'd2, 64'h2000, 2'd0, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      bif.ar_issue_valid = 1'b1; bif.ar_issue_tag = 4'd2; bif.ar_issue_len = 8'd0;
      beat(4'd2, 64'h2001, 2'd0, 1'b1, 1, 1, 2'd0, 1'b0, 8'd2, 0, 0);
      bif.ar_issue_valid = 1'b0;
      beat(4'd2, 64'h2002, 2'd3, 1'b1, 1, 1, 2'd3, 1'b1, 8'd1, 0, 0);
      err_delta("err_reissue", e0, 0);

      // Issue on tag 10 while tag 9 completes.
      e0 = err_cnt;
      issue(4'd9, 8'd0);
      bif.ar_issue_valid = 1'b1; bif.ar_issue_tag = 4'd10; bif.ar_issue_len = 8'd0;
      beat(4'd9, 64'h9000, 2'd0, 1'b1, 1, 1, 2'd0, 1'b0, 8'd1, 0, 0);
      bif.ar_issue_valid = 1'b0;
      beat(4'd10, 64'hA000, 2'd1, 1'b1, 1, 1, 2'd1, 1'b0, 8'd1, 0, 0);
      err_delta("err_indep", e0, 0);

      // Double issue on an active tag is ignored and flagged.
      e0 = err_cnt;
      issue(4'd4, 8'd0);
      issue(4'd4, 8'd5);
      err_delta("err_double_issue", e0, 1);
      beat(4'd4, 64'h4000, 2'd0, 1'b1, 1, 1, 2'd0, 1'b0, 8'd1, 0, 0);

      // Response accumulation picks the numeric maximum.
      issue(4'd13, 8'd2);
      beat(4'd13, 64'hD000, 2'd1, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      beat(4'd13, 64'hD001, 2'd3, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      beat(4'd13, 64'hD002, 2'd0, 1'b1, 1, 1, 2'd3, 1'b1, 8'd3, 0, 0);

      // rlast before ARLEN is reached.
      e0 = err_cnt;
      issue(4'd14, 8'd3);
      beat(4'd14, 64'hE000, 2'd0, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 0, 0);
`ifdef APB2AXI_RLEN_CHECK_EN
      beat(4'd14, 64'hE001, 2'd0, 1'b1, 1, 1, 2'd0, 1'b1, 8'd2, 0, 0);
`else
      beat(4'd14, 64'hE001, 2'd0, 1'b1, 1, 1, 2'd0, 1'b0, 8'd2, 0, 0);
`endif
      err_delta("err_short_burst", e0, 0);

`ifdef APB2AXI_RLEN_CHECK_EN
      // Missing rlast: the ARLEN-th beat closes the burst, the next beat is stray.
      e0 = err_cnt;
      issue(4'd15, 8'd1);
      beat(4'd15, 64'hF000, 2'd0, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      beat(4'd15, 64'hF001, 2'd0, 1'b0, 1, 1, 2'd0, 1'b1, 8'd2, 0, 0);
      beat(4'd15, 64'hF002, 2'd0, 1'b0, 0, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      err_delta("err_forced_end", e0, 2);
`else
      // 300-beat burst: the reported beat count saturates.
      issue(4'd6, 8'd0);
      for (int i = 0; i < 300; i++)
         beat(4'd6, 64'h6000 + 64'(i), 2'd0, i == 299, 1, i == 299, 2'd0, 1'b0, 8'hFF, 0, 0);
`endif

      // Reset in the middle of a burst abandons it.
      issue(4'd11, 8'd3);
      beat(4'd11, 64'hB000, 2'd0, 1'b0, 1, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      aresetn = 1'b0;
      #1;
      chk("midrst_rready", bif.rready, 1'b0);
      tick();
      aresetn = 1'b1;
      tick();
      e0 = err_cnt;
      beat(4'd11, 64'hB001, 2'd0, 1'b1, 0, 0, 2'd0, 1'b0, 8'd0, 0, 0);
      err_delta("err_after_reset", e0, 1);

      tick();
      chk("rdf_q_drained", rdf_q.size(), 0);
      chk("cpl_q_drained", cpl_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
